game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000: vga_clk cycles per movement tick, legal range 2..2^20.
REQ-002 Parameter LIVES, default 3: lives loaded at game start, legal range 1..3.
REQ-003 Parameter HIT_FRAMES, default 60: frames spent in HIT state, legal range 1..255.
REQ-004 Parameter WIN_SCORE, default 16: coin count that wins the game, legal range 1..65535, used only with SEQ_WIN_EN.
REQ-005 vga_clk  in  1  single 25 MHz clock; one clock only; all logic on its rising edge.
REQ-006 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-008 btn_start  in  1  start/acknowledge button, level, already synchronised to vga_clk.
REQ-009 hit_enemy  in  1  player/enemy overlap flag, level.
REQ-010 hit_coin  in  1  player/coin overlap flag, level.
REQ-011 tick_en  out  1  one-cycle movement enable that replaces the derived enemy clock.
REQ-012 play_active  out  1  high only in the PLAY state.
REQ-013 respawn  out  1  one-cycle pulse that returns the player and enemy to their start positions.
REQ-014 coin_relocate  out  1  one-cycle pulse that moves the coin.
REQ-015 lives  out  2  remaining lives.
REQ-016 score  out  16  coins collected.
REQ-017 flash  out  1  screen overlay request.
REQ-018 state  out  3  current state encoding.

Function
REQ-019 The state machine SHALL have these states and encodings: IDLE=0, PLAY=1, HIT=2, OVER=3, WIN=4.
REQ-020 A start edge SHALL be defined as btn_start=1 in the current cycle with the registered btn_start=0 from the previous cycle.
REQ-021 In IDLE, a start edge SHALL, on the same clock edge: move to PLAY, load lives with LIVES, clear score, pulse respawn for 1 cycle, and clear the tick counter.
REQ-022 In PLAY, the tick counter SHALL count 0..TICK_DIV-1 and wrap, with tick_en=1 in the cycle where the count equals TICK_DIV-1.
REQ-023 Outside PLAY, tick_en SHALL be 0 and the tick counter SHALL hold at 0.
REQ-024 In PLAY, hit_enemy SHALL be sampled only when frame_start=1; if it is 1, the block SHALL move to HIT, decrement lives, and clear the frame counter.
REQ-025 In PLAY, a rising edge of hit_coin SHALL increment score, saturating at 16'hFFFF, and pulse coin_relocate in the next cycle.
REQ-026 If a hit_coin rising edge and a qualifying hit_enemy sample occur in the same cycle, the enemy hit SHALL win: no score change and no coin_relocate pulse.
REQ-027 In HIT, the frame counter SHALL increment on each frame_start, and flash SHALL equal bit 3 of the frame counter (toggles every 8 frames).
REQ-028 In HIT, when the frame counter reaches HIT_FRAMES: if lives=0 the block SHALL move to OVER, otherwise it SHALL move to PLAY with a 1-cycle respawn pulse.
REQ-029 In OVER, flash SHALL be held at 1, and a start edge SHALL move the block to IDLE with lives and score held until the next game start.
REQ-030 In all other states and cases, flash SHALL be 0; hit_enemy and hit_coin SHALL be ignored outside PLAY.
REQ-031 A start edge in PLAY or HIT SHALL have no effect.

Reset
REQ-032 While arst_n=0, the block SHALL hold: state=IDLE, lives=0, score=0, tick_en=0, respawn=0, coin_relocate=0, flash=0, all counters 0, and all edge-detect registers 0.
REQ-033 When reset asserts mid-game, the block SHALL abandon the game immediately; the first start edge after reset release SHALL behave as in REQ-021.

Configuration
REQ-034 Macro GAME_SEQ_WIN_EN SHALL select the win feature: when defined, a score increment that makes score equal WIN_SCORE SHALL move the block from PLAY to WIN.
REQ-035 In WIN, flash SHALL be 1, and a start edge SHALL move the block to IDLE.
REQ-036 When GAME_SEQ_WIN_EN is undefined, the WIN state SHALL be unreachable, and score SHALL only saturate.

Structure
REQ-037 Package game_pkg SHALL hold the state encoding typedef, the state width constant, and the score width constant.
REQ-038 The tick divider SHALL be sub-module tick_gen, with ports clock, reset, enable and tick, and parameter DIV.

Verification
REQ-039 Bench SHALL use TICK_DIV=4, HIT_FRAMES=4, LIVES=2, WIN_SCORE=3 unless stated.
REQ-040 Game start: reset, then a btn_start edge -> state=1, lives=2, score=0, one respawn pulse, then tick_en every 4th cycle.
REQ-041 Enemy hit and respawn: hit_enemy=1 held over a frame_start -> state=2, lives=1; after 4 frame_starts -> state=1 with respawn pulse; second hit -> lives=0, then state=3 after 4 frames.
REQ-042 Coin scoring: hit_coin held high for 10 cycles -> score +1 exactly, one coin_relocate pulse; with GAME_SEQ_WIN_EN, 3 coin edges -> state=4, tick_en=0.
REQ-043 Simultaneous events: hit_coin rising edge in the same cycle as a qualifying hit_enemy sample -> score unchanged, no coin_relocate, state=2.
REQ-044 Reset mid-operation and saturation: arst_n pulsed low in HIT -> all outputs at reset values immediately; score preloaded to 16'hFFFF plus one coin -> stays 16'hFFFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding, widths and score arithmetic for the game sequencer.
package game_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SCORE_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_OVER = 3'd3,
        ST_WIN  = 3'd4
    } game_state_t;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Movement tick divider: one-cycle tick every DIV enabled cycles.
// The count parks at zero whenever enable is low.
module tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // reset is active-low and asynchronous
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Game flow sequencer: IDLE -> PLAY -> HIT -> PLAY/OVER, with optional WIN.
// Define GAME_SEQ_WIN_EN to let reaching WIN_SCORE coins end the game in WIN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned HIT_FRAMES = 60,
    parameter int unsigned WIN_SCORE  = 16
) (
    input  logic               vga_clk,
    input  logic               arst_n,
    input  logic               frame_start,
    input  logic               btn_start,
    input  logic               hit_enemy,
    input  logic               hit_coin,
    output logic               tick_en,
    output logic               play_active,
    output logic               respawn,
    output logic               coin_relocate,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               flash,
    output logic [STATE_W-1:0] state
);

`ifdef GAME_SEQ_WIN_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
    localparam logic [7:0]         HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    game_state_t        cur;
    logic               btn_d;
    logic               coin_d;
    logic [7:0]         frame_cnt;
    logic [1:0]         lives_r;
    logic [SCORE_W-1:0] score_r;
    logic [SCORE_W-1:0] score_nxt;
    logic               respawn_r;
    logic               relocate_r;

    logic start_edge;
    logic enemy_hit;
    logic coin_take;
    logic win_hit;

    assign start_edge = btn_start && !btn_d;
    assign enemy_hit  = (cur == ST_PLAY) && frame_start && hit_enemy;
    // An enemy hit in the same cycle swallows the coin pickup.
    assign coin_take  = (cur == ST_PLAY) && hit_coin && !coin_d && !enemy_hit;

    always_comb begin
        score_nxt = score_r;
        if (cur == ST_IDLE && start_edge) begin
            score_nxt = '0;
        end else if (coin_take) begin
            score_nxt = score_inc(score_r);
        end
    end

    assign win_hit = coin_take && (score_r != '1) && (score_nxt == WIN_VAL);

    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            cur        <= ST_IDLE;
            btn_d      <= 1'b0;
            coin_d     <= 1'b0;
            frame_cnt  <= '0;
            lives_r    <= '0;
            score_r    <= '0;
            respawn_r  <= 1'b0;
            relocate_r <= 1'b0;
        end else begin
            btn_d      <= btn_start;
            coin_d     <= hit_coin;
            score_r    <= score_nxt;
            respawn_r  <= 1'b0;
            relocate_r <= coin_take;
            case (cur)
                ST_IDLE: begin
                    if (start_edge) begin
                        cur       <= ST_PLAY;
                        lives_r   <= LIVES_INIT;
                        respawn_r <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (enemy_hit) begin
                        cur       <= ST_HIT;
                        lives_r   <= lives_r - 2'd1;
                        frame_cnt <= '0;
                    end else if (WIN_EN && win_hit) begin
                        cur <= ST_WIN;
                    end
                end
                ST_HIT: begin
                    if (frame_start) begin
                        if (frame_cnt == HIT_LAST) begin
                            frame_cnt <= '0;
                            if (lives_r == 2'd0) begin
                                cur <= ST_OVER;
                            end else begin
                                cur       <= ST_PLAY;
                                respawn_r <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_OVER, ST_WIN: begin
                    if (start_edge) begin
                        cur <= ST_IDLE;
                    end
                end
                default: cur <= ST_IDLE;
            endcase
        end
    end

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clock  (vga_clk),
        .reset  (arst_n),
        .enable (cur == ST_PLAY),
        .tick   (tick_en)
    );

    assign state         = cur;
    assign play_active   = (cur == ST_PLAY);
    assign respawn       = respawn_r;
    assign coin_relocate = relocate_r;
    assign lives         = lives_r;
    assign score         = score_r;
    assign flash         = (cur == ST_HIT)  ? frame_cnt[3]
                         : (cur == ST_OVER) || (cur == ST_WIN);

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus random soak,
// compared every cycle against a behavioural game model.
module tb_game_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int LIVES      = 2;
    localparam int HIT_FRAMES = 4;
    localparam int WIN_SCORE  = 3;

`ifdef GAME_SEQ_WIN_EN
    localparam bit WIN_ON = 1'b1;
`else
    localparam bit WIN_ON = 1'b0;
`endif

    localparam int S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_OVER = 3, S_WIN = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        btn_start = 1'b0;
    logic        hit_enemy = 1'b0;
    logic        hit_coin = 1'b0;
    logic        tick_en;
    logic        play_active;
    logic        respawn;
    logic        coin_relocate;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        flash;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural game model
    int m_state = 0, m_lives = 0, m_score = 0, m_frames = 0, m_play_cyc = 0;
    bit m_btn_d = 0, m_coin_d = 0, m_respawn = 0, m_reloc = 0;

    game_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .LIVES      (LIVES),
        .HIT_FRAMES (HIT_FRAMES),
        .WIN_SCORE  (WIN_SCORE)
    ) dut (
        .vga_clk       (clk),
        .arst_n        (arst_n),
        .frame_start   (frame_start),
        .btn_start     (btn_start),
        .hit_enemy     (hit_enemy),
        .hit_coin      (hit_coin),
        .tick_en       (tick_en),
        .play_active   (play_active),
        .respawn       (respawn),
        .coin_relocate (coin_relocate),
        .lives         (lives),
        .score         (score),
        .flash         (flash),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit start, cedge, inc;
        if (!arst_n) begin
            m_state = S_IDLE; m_lives = 0; m_score = 0; m_frames = 0; m_play_cyc = 0;
            m_btn_d = 0; m_coin_d = 0; m_respawn = 0; m_reloc = 0;
            return;
        end
        start = btn_start && !m_btn_d;
        cedge = hit_coin && !m_coin_d;
        m_respawn = 0;
        m_reloc = 0;
        case (m_state)
            S_IDLE: if (start) begin
                m_state = S_PLAY; m_lives = LIVES; m_score = 0;
                m_respawn = 1; m_play_cyc = 0;
            end
            S_PLAY: begin
                m_play_cyc++;
                if (frame_start && hit_enemy) begin
                    m_state = S_HIT; m_lives--; m_frames = 0;
                end else if (cedge) begin
                    m_reloc = 1;
                    inc = (m_score < 65535);
                    if (inc) m_score++;
                    if (WIN_ON && inc && m_score == WIN_SCORE) m_state = S_WIN;
                end
            end
            S_HIT: if (frame_start) begin
                m_frames++;
                if (m_frames == HIT_FRAMES) begin
                    if (m_lives == 0) m_state = S_OVER;
                    else begin
                        m_state = S_PLAY; m_respawn = 1; m_play_cyc = 0;
                    end
                end
            end
            default: if (start) m_state = S_IDLE;
        endcase
        m_btn_d = btn_start;
        m_coin_d = hit_coin;
    endtask

    // Compare process: model advances on each rising edge, outputs checked just after
    initial begin
        bit exp_tick, exp_flash;
        forever begin
            @(posedge clk);
            model_step();
            #2;
            exp_tick  = (m_state == S_PLAY) && (m_play_cyc % TICK_DIV == TICK_DIV - 1);
            exp_flash = (m_state == S_HIT) ? ((m_frames >> 3) & 1) != 0
                                           : (m_state == S_OVER || m_state == S_WIN);
            check("state", 32'(state), 32'(m_state));
            check("lives", 32'(lives), 32'(m_lives));
            check("score", 32'(score), 32'(m_score));
            check("tick_en", 32'(tick_en), 32'(exp_tick));
            check("play_active", 32'(play_active), 32'(m_state == S_PLAY));
            check("respawn", 32'(respawn), 32'(m_respawn));
            check("coin_relocate", 32'(coin_relocate), 32'(m_reloc));
            check("flash", 32'(flash), 32'(exp_flash));
        end
    end

    task automatic press();
        @(negedge clk) btn_start = 1'b1;
        @(negedge clk) btn_start = 1'b0;
    endtask

    task automatic coin_pulse();
        @(negedge clk) hit_coin = 1'b1;
        @(negedge clk) hit_coin = 1'b0;
    endtask

    task automatic enemy_hit_frame();
        @(negedge clk) begin hit_enemy = 1'b1; frame_start = 1'b1; end
        @(negedge clk) begin hit_enemy = 1'b0; frame_start = 1'b0; end
    endtask

    task automatic hit_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_start = 1'b1;
            @(negedge clk) frame_start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int ticks, pulses;
        int sim_score;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_lives", 32'(lives), 0);
        check("rst_score", 32'(score), 0);
        check("rst_tick", 32'(tick_en), 0);
        arst_n = 1'b1;

        // Collisions in IDLE are ignored
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            frame_start = 1'($urandom_range(1));
            hit_enemy   = 1'($urandom_range(1));
            hit_coin    = 1'($urandom_range(1));
        end
        @(negedge clk) begin frame_start = 0; hit_enemy = 0; hit_coin = 0; end

        // Game start
        @(negedge clk) btn_start = 1'b1;
        @(negedge clk);
        check("start_state", 32'(state), 1);
        check("start_lives", 32'(lives), 2);
        check("start_score", 32'(score), 0);
        check("start_respawn", 32'(respawn), 1);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_start = 1'b0;
            if (tick_en) ticks++;
        end
        check("tick_count_8cyc", 32'(ticks), 2);
        check("start_respawn_once", 32'(respawn), 0);

        // Coin held for 10 cycles counts once
        @(negedge clk) hit_coin = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (coin_relocate) pulses++;
        end
        hit_coin = 1'b0;
        @(negedge clk);
        if (coin_relocate) pulses++;
        check("coin_hold_score", 32'(score), 1);
        check("coin_hold_relocate", 32'(pulses), 1);

        coin_pulse();
        coin_pulse();
        @(negedge clk);
        check("coin3_score", 32'(score), 3);
        if (WIN_ON) begin
            check("win_state", 32'(state), 4);
            check("win_tick", 32'(tick_en), 0);
            check("win_flash", 32'(flash), 1);
            press();
            check("win_to_idle", 32'(state), 0);
            press();
            check("win_restart", 32'(state), 1);
            sim_score = 0;
        end else begin
            check("nowin_state", 32'(state), 1);
            sim_score = 3;
        end

        // Coin edge and enemy sample in the same cycle
        @(negedge clk) begin hit_coin = 1; hit_enemy = 1; frame_start = 1; end
        @(negedge clk) begin hit_enemy = 0; frame_start = 0; end
        check("sim_state", 32'(state), 2);
        check("sim_lives", 32'(lives), 1);
        check("sim_score", 32'(score), 32'(sim_score));
        check("sim_relocate", 32'(coin_relocate), 0);
        hit_coin = 1'b0;

        hit_frames(HIT_FRAMES - 1);
        check("hit_holding", 32'(state), 2);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        check("hit_exit_state", 32'(state), 1);
        check("hit_exit_respawn", 32'(respawn), 1);

        // Random play without enemy contact
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            frame_start = ($urandom_range(3) == 0);
            hit_coin    = WIN_ON ? 1'b0 : 1'($urandom_range(1));
        end
        @(negedge clk) begin frame_start = 0; hit_coin = 0; end

        // Second hit ends the game
        enemy_hit_frame();
        check("hit2_lives", 32'(lives), 0);
        check("hit2_state", 32'(state), 2);
        hit_frames(HIT_FRAMES);
        check("over_state", 32'(state), 3);
        check("over_flash", 32'(flash), 1);
        check("over_respawn", 32'(respawn), 0);
        press();
        check("over_idle_state", 32'(state), 0);
        check("over_idle_lives", 32'(lives), 0);
        check("over_idle_score", 32'(score), 32'(m_score));
        press();
        check("restart_lives", 32'(lives), 2);
        check("restart_score", 32'(score), 0);

        // Reset asserted mid-HIT
        enemy_hit_frame();
        check("pre_rst_state", 32'(state), 2);
        @(negedge clk) arst_n = 1'b0;
        #1;
        check("midrst_state", 32'(state), 0);
        check("midrst_lives", 32'(lives), 0);
        check("midrst_score", 32'(score), 0);
        check("midrst_flash", 32'(flash), 0);
        check("midrst_tick", 32'(tick_en), 0);
        check("midrst_respawn", 32'(respawn), 0);
        @(negedge clk) arst_n = 1'b1;
        press();
        check("post_rst_state", 32'(state), 1);
        check("post_rst_lives", 32'(lives), 2);
        check("post_rst_respawn", 32'(respawn), 1);

        // Score saturation from a preloaded 16'hFFFF
        @(negedge clk) begin
            force dut.score_r = 16'hFFFF;
            m_score = 65535;
        end
        @(negedge clk) release dut.score_r;
        coin_pulse();
        check("sat_score", 32'(score), 32'hFFFF);
        check("sat_relocate", 32'(coin_relocate), 1);
        @(negedge clk);
        check("sat_score_hold", 32'(score), 32'hFFFF);

        // Random soak over the whole game flow
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            btn_start   = ($urandom_range(7) == 0);
            frame_start = ($urandom_range(3) == 0);
            hit_enemy   = ($urandom_range(2) == 0);
            hit_coin    = 1'($urandom_range(1));
            arst_n      = ($urandom_range(299) != 0);
        end
        @(negedge clk) begin
            arst_n = 1; btn_start = 0; frame_start = 0; hit_enemy = 0; hit_coin = 0;
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
